// File: rtl/imem_loader.sv
// imem_loader: byte-addressed instruction memory plus program loader.
//   Loads a program from a valid/ready byte stream after zero-filling the whole
//   memory, holds the pipeline in reset until the load completes, and serves
//   fetch with a little-endian window of FETCH_BYTES bytes starting at f_pc.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ld_start, ld_len  load request and program length (1..MEM_BYTES)
//   ld_data, ld_valid program byte stream; ld_ready is the handshake reply
//   ld_done, ld_err   high while running / while in the error state
//   ld_csum           mod-256 sum of bytes accepted in the current load
//   cpu_rst           pipeline reset, low only while running
//   f_pc, f_instr     fetch address and instruction window
//   f_imem_error      fetch address beyond the end of memory
module imem_loader #(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned FETCH_BYTES = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_start,
    input  logic [ADDR_W:0]          ld_len,
    input  logic [7:0]               ld_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    output logic                     ld_done,
    output logic                     ld_err,
    output logic [7:0]               ld_csum,
    output logic                     cpu_rst,
    input  logic [63:0]              f_pc,
    output logic [8*FETCH_BYTES-1:0] f_instr,
    output logic                     f_imem_error
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        ERR
    } state_t;

    localparam logic [ADDR_W:0]   MEM_LEN   = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W:0]   len;
    logic [7:0]        mem [MEM_BYTES];

    logic              lenOk;
    logic              accept;
    logic              lastBeat;
    logic              memWe;
    logic [7:0]        memWdata;
    logic [63:0]       byteAddr;

    assign lenOk    = (ld_len != '0) && (ld_len <= MEM_LEN);
    assign accept   = ld_valid && ld_ready;
    assign lastBeat = ({1'b0, cnt} == (len - 1'b1));

    // Clearing and loading share one write port addressed by cnt.
    assign memWe    = !rst && ((state == CLEAR) || accept);
    assign memWdata = (state == CLEAR) ? '0 : ld_data;

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[cnt] <= memWdata;
        end
    end

    // Outputs are registered alongside state so each one always equals the
    // decode of the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            len      <= '0;
            ld_csum  <= '0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            ld_err   <= 1'b0;
            cpu_rst  <= 1'b1;
        end else begin
            case (state)
                IDLE, RUN, ERR: begin
                    if (ld_start) begin
                        ld_ready <= 1'b0;
                        ld_done  <= 1'b0;
                        cpu_rst  <= 1'b1;
                        if (lenOk) begin
                            state   <= CLEAR;
                            len     <= ld_len;
                            cnt     <= '0;
                            ld_csum <= '0;
                            ld_err  <= 1'b0;
                        end else begin
                            state  <= ERR;
                            ld_err <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        cnt      <= '0;
                        state    <= LOAD;
                        ld_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        ld_csum <= ld_csum + ld_data;
                        cnt     <= cnt + 1'b1;
                        if (lastBeat) begin
                            state    <= RUN;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                            cpu_rst  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    ld_ready <= 1'b0;
                    ld_done  <= 1'b0;
                    ld_err   <= 1'b0;
                    cpu_rst  <= 1'b1;
                end
            endcase
        end
    end

    // Full 64-bit address per byte, so a high f_pc never aliases into memory.
    always_comb begin
        f_instr  = '0;
        byteAddr = '0;
        for (int unsigned i = 0; i < FETCH_BYTES; i++) begin
            byteAddr = f_pc + 64'(i);
            if (byteAddr < 64'(MEM_BYTES)) begin
                f_instr[8*i +: 8] = mem[byteAddr[ADDR_W-1:0]];
            end
        end
    end

    assign f_imem_error = (f_pc >= 64'(MEM_BYTES));

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scenario tasks for imem_loader, checked against a byte-array
// model of memory contents and arithmetic expectations for timing and checksum.
module tb_imem_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_start = 1'b0;
    logic [10:0] ld_len = '0;
    logic [7:0]  ld_data = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic        ld_done;
    logic        ld_err;
    logic [7:0]  ld_csum;
    logic        cpu_rst;
    logic [63:0] f_pc = '0;
    logic [79:0] f_instr;
    logic        f_imem_error;

    int nChecks = 0;
    int nFail   = 0;

    logic [7:0] refMem [1024];

    imem_loader #(
        .MEM_BYTES(1024),
        .ADDR_W(10),
        .FETCH_BYTES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ld_start(ld_start),
        .ld_len(ld_len),
        .ld_data(ld_data),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_done(ld_done),
        .ld_err(ld_err),
        .ld_csum(ld_csum),
        .cpu_rst(cpu_rst),
        .f_pc(f_pc),
        .f_instr(f_instr),
        .f_imem_error(f_imem_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startLoad(input int len);
        ld_start = 1'b1;
        ld_len   = 11'(len);
        tick();
        ld_start = 1'b0;
    endtask

    task automatic waitReady(output int cycles);
        cycles = 0;
        while (ld_ready !== 1'b1 && cycles < 2000) begin
            tick();
            cycles++;
        end
    endtask

    // Drives the stream; gapPct is the chance of an idle cycle per beat.
    task automatic sendBytes(input bq_t q, input int gapPct, output int cycles, output int accepted);
        int  idx;
        bit  v;
        bit  rdy;
        idx    = 0;
        cycles = 0;
        while (idx < q.size() && cycles < 20000) begin
            v        = ($urandom_range(0, 99) >= gapPct);
            ld_valid = v;
            ld_data  = v ? q[idx] : 8'($urandom);
            rdy      = (ld_ready === 1'b1);
            tick();
            cycles++;
            if (v && rdy) idx++;
        end
        ld_valid = 1'b0;
        accepted = idx;
    endtask

    task automatic modelLoad(input bq_t q);
        for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
        for (int i = 0; i < q.size(); i++) refMem[i] = q[i];
    endtask

    function automatic logic [79:0] expWin(input logic [63:0] pc);
        logic [79:0] w;
        logic [63:0] a;
        w = '0;
        for (int i = 0; i < 10; i++) begin
            a = pc + 64'(i);
            if (a < 64'd1024) w = w | (80'(refMem[a[9:0]]) << (8 * i));
        end
        return w;
    endfunction

    function automatic logic [7:0] sumOf(input bq_t q);
        logic [7:0] s;
        s = 8'h00;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        nChecks++; if (cpu_rst !== 1'b1) begin nFail++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
        nChecks++; if (ld_ready !== 1'b0) begin nFail++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
        nChecks++; if (ld_done !== 1'b0) begin nFail++; $display("FAIL reset_ld_done: got %b want 0", ld_done); end
        nChecks++; if (ld_err !== 1'b0) begin nFail++; $display("FAIL reset_ld_err: got %b want 0", ld_err); end
        nChecks++; if (ld_csum !== 8'h00) begin nFail++; $display("FAIL reset_ld_csum: got %h want 00", ld_csum); end
        rst = 1'b0;
        tick();
        nChecks++; if (cpu_rst !== 1'b1 || ld_ready !== 1'b0) begin nFail++; $display("FAIL idle_hold: got cpu_rst=%b ready=%b want 1/0", cpu_rst, ld_ready); end
    endtask

    task automatic test_basic_load();
        bq_t q;
        int  cyc;
        int  acc;
        q = {8'h30, 8'hF2, 8'h05};
        startLoad(3);
        nChecks++; if (ld_ready !== 1'b0 || cpu_rst !== 1'b1) begin nFail++; $display("FAIL basic_clear_outputs: got ready=%b cpu_rst=%b want 0/1", ld_ready, cpu_rst); end
        waitReady(cyc);
        nChecks++; if (cyc !== 1024) begin nFail++; $display("FAIL basic_clear_cycles: got %0d want 1024", cyc); end
        sendBytes(q, 0, cyc, acc);
        nChecks++; if (cyc !== 3 || acc !== 3) begin nFail++; $display("FAIL basic_beats: got cycles=%0d accepted=%0d want 3/3", cyc, acc); end
        nChecks++; if (ld_done !== 1'b1 || cpu_rst !== 1'b0 || ld_ready !== 1'b0) begin nFail++; $display("FAIL basic_run: got done=%b cpu_rst=%b ready=%b want 1/0/0", ld_done, cpu_rst, ld_ready); end
        nChecks++; if (ld_csum !== 8'h27) begin nFail++; $display("FAIL basic_csum: got %h want 27", ld_csum); end
        modelLoad(q);
        f_pc = 64'd0;
        #1;
        nChecks++; if (f_instr !== 80'h05F230) begin nFail++; $display("FAIL basic_fetch: got %h want %h", f_instr, 80'h05F230); end
        nChecks++; if (f_imem_error !== 1'b0) begin nFail++; $display("FAIL basic_fetch_err: got %b want 0", f_imem_error); end
    endtask

    // Reload straight from RUN, with ld_start pulses during CLEAR and LOAD
    // that must be ignored, and ld_valid alternating 1/0.
    task automatic test_valid_toggle();
        bq_t        q;
        int         cyc;
        logic [7:0] sum;
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom_range(1, 255)));
        startLoad(4);
        nChecks++; if (cpu_rst !== 1'b1 || ld_done !== 1'b0) begin nFail++; $display("FAIL reload_leave_run: got cpu_rst=%b done=%b want 1/0", cpu_rst, ld_done); end
        ld_start = 1'b1;
        ld_len   = 11'd0;
        tick();
        ld_start = 1'b0;
        nChecks++; if (ld_err !== 1'b0) begin nFail++; $display("FAIL start_in_clear: got err=%b want 0", ld_err); end
        waitReady(cyc);
        nChecks++; if (cyc !== 1023) begin nFail++; $display("FAIL reload_clear_cycles: got %0d want 1023", cyc); end
        sum = 8'h00;
        for (int k = 0; k < 4; k++) begin
            ld_valid = 1'b1;
            ld_data  = q[k];
            tick();
            sum = sum + q[k];
            nChecks++; if (ld_csum !== sum) begin nFail++; $display("FAIL toggle_csum_beat%0d: got %h want %h", k, ld_csum, sum); end
            if (k < 3) begin
                ld_valid = 1'b0;
                ld_data  = ~q[k];
                ld_start = 1'b1;
                ld_len   = 11'd0;
                tick();
                ld_start = 1'b0;
                nChecks++; if (ld_csum !== sum) begin nFail++; $display("FAIL toggle_idle%0d_csum: got %h want %h", k, ld_csum, sum); end
                nChecks++; if (ld_ready !== 1'b1 || ld_err !== 1'b0 || ld_done !== 1'b0) begin nFail++; $display("FAIL toggle_idle%0d_state: got ready=%b err=%b done=%b want 1/0/0", k, ld_ready, ld_err, ld_done); end
            end
        end
        nChecks++; if (ld_done !== 1'b1 || ld_csum !== sumOf(q)) begin nFail++; $display("FAIL toggle_run: got done=%b csum=%h want 1/%h", ld_done, ld_csum, sumOf(q)); end
        modelLoad(q);
        f_pc = 64'd0;
        #1;
        nChecks++; if (f_instr !== expWin(64'd0)) begin nFail++; $display("FAIL toggle_fetch: got %h want %h", f_instr, expWin(64'd0)); end
    endtask

    task automatic test_error();
        bq_t q;
        int  cyc;
        int  acc;
        q = {8'h10};
        startLoad(0);
        nChecks++; if (ld_err !== 1'b1 || cpu_rst !== 1'b1 || ld_done !== 1'b0) begin nFail++; $display("FAIL err_len0: got err=%b cpu_rst=%b done=%b want 1/1/0", ld_err, cpu_rst, ld_done); end
        startLoad(1025);
        tick();
        nChecks++; if (ld_err !== 1'b1 || ld_ready !== 1'b0) begin nFail++; $display("FAIL err_len1025: got err=%b ready=%b want 1/0", ld_err, ld_ready); end
        startLoad(1);
        nChecks++; if (ld_err !== 1'b0 || cpu_rst !== 1'b1) begin nFail++; $display("FAIL err_recover: got err=%b cpu_rst=%b want 0/1", ld_err, cpu_rst); end
        waitReady(cyc);
        nChecks++; if (cyc !== 1024) begin nFail++; $display("FAIL err_clear_cycles: got %0d want 1024", cyc); end
        sendBytes(q, 0, cyc, acc);
        nChecks++; if (ld_done !== 1'b1 || cpu_rst !== 1'b0 || ld_csum !== 8'h10) begin nFail++; $display("FAIL err_len1_run: got done=%b cpu_rst=%b csum=%h want 1/0/10", ld_done, cpu_rst, ld_csum); end
        modelLoad(q);
        f_pc = 64'd0;
        #1;
        nChecks++; if (f_instr !== expWin(64'd0)) begin nFail++; $display("FAIL err_fetch: got %h want %h", f_instr, expWin(64'd0)); end
    endtask

    task automatic test_full_load();
        bq_t         q;
        int          cyc;
        int          acc;
        logic [63:0] pcs[$];
        for (int i = 0; i < 1024; i++) q.push_back(8'($urandom_range(1, 255)));
        startLoad(1024);
        waitReady(cyc);
        sendBytes(q, 30, cyc, acc);
        nChecks++; if (acc !== 1024 || ld_done !== 1'b1) begin nFail++; $display("FAIL full_accept: got accepted=%0d done=%b want 1024/1", acc, ld_done); end
        nChecks++; if (ld_csum !== sumOf(q)) begin nFail++; $display("FAIL full_csum: got %h want %h", ld_csum, sumOf(q)); end
        modelLoad(q);
        pcs = {64'd0, 64'd1014, 64'd1015, 64'd1020, 64'd1023, 64'd1024, 64'd1025, 64'h1_0000_0000, 64'h1_0000_0400};
        for (int i = 0; i < 4; i++) pcs.push_back(64'($urandom_range(0, 1023)));
        foreach (pcs[i]) begin
            f_pc = pcs[i];
            #1;
            nChecks++; if (f_instr !== expWin(pcs[i])) begin nFail++; $display("FAIL window_pc%0d: got %h want %h", pcs[i], f_instr, expWin(pcs[i])); end
            nChecks++; if (f_imem_error !== (pcs[i] >= 64'd1024)) begin nFail++; $display("FAIL imem_err_pc%0d: got %b want %b", pcs[i], f_imem_error, pcs[i] >= 64'd1024); end
        end
        f_pc = 64'd1020;
        #1;
        nChecks++; if (f_instr[79:32] !== 48'h0 || f_imem_error !== 1'b0) begin nFail++; $display("FAIL edge_1020: got hi=%h err=%b want 0/0", f_instr[79:32], f_imem_error); end
        f_pc = 64'd1024;
        #1;
        nChecks++; if (f_instr !== 80'h0 || f_imem_error !== 1'b1) begin nFail++; $display("FAIL edge_1024: got %h err=%b want 0/1", f_instr, f_imem_error); end
        f_pc = 64'd0;
    endtask

    task automatic test_rst_midload();
        bq_t         q5;
        bq_t         q2;
        int          cyc;
        int          acc;
        logic [79:0] w;
        for (int i = 0; i < 2; i++) q5.push_back(8'($urandom_range(1, 255)));
        for (int i = 0; i < 2; i++) q2.push_back(8'($urandom_range(1, 255)));
        startLoad(5);
        waitReady(cyc);
        sendBytes(q5, 0, cyc, acc);
        nChecks++; if (ld_ready !== 1'b1 || ld_done !== 1'b0) begin nFail++; $display("FAIL mid_load_state: got ready=%b done=%b want 1/0", ld_ready, ld_done); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nChecks++; if (cpu_rst !== 1'b1 || ld_ready !== 1'b0 || ld_done !== 1'b0 || ld_err !== 1'b0 || ld_csum !== 8'h00) begin nFail++; $display("FAIL mid_rst: got cpu_rst=%b ready=%b done=%b err=%b csum=%h want 1/0/0/0/00", cpu_rst, ld_ready, ld_done, ld_err, ld_csum); end
        startLoad(2);
        waitReady(cyc);
        nChecks++; if (cyc !== 1024) begin nFail++; $display("FAIL mid_reclear_cycles: got %0d want 1024", cyc); end
        sendBytes(q2, 20, cyc, acc);
        nChecks++; if (ld_done !== 1'b1 || ld_csum !== sumOf(q2)) begin nFail++; $display("FAIL mid_reload_run: got done=%b csum=%h want 1/%h", ld_done, ld_csum, sumOf(q2)); end
        modelLoad(q2);
        f_pc = 64'd0;
        #1;
        w = f_instr;
        nChecks++; if (w[39:16] !== 24'h0) begin nFail++; $display("FAIL mid_recleared: got %h want 000000", w[39:16]); end
        nChecks++; if (w !== expWin(64'd0)) begin nFail++; $display("FAIL mid_fetch: got %h want %h", w, expWin(64'd0)); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_valid_toggle();
        test_error();
        test_full_load();
        test_rst_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
